// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS fetch stage.
// Fetch FSM states, next-PC select encoding, PC width, default reset PC.
package mips_pkg;

    localparam int PC_WIDTH = 32;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        HALT  = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        BRANCH = 2'd1,
        JUMP   = 2'd2
    } npc_sel_e;

    function automatic logic [31:0] pc_inc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Priority next-PC select (jump > branch > sequential) with jump-target formation.
// With PC_ALIGN_CHECK_EN undefined the low two target bits are forced to zero.
import mips_pkg::*;

module pc_next_mux (
    input  logic [31:0] pc_seq,
    input  logic [3:0]  pc_region,
    input  logic [31:0] pcbranch,
    input  logic        jump,
    input  logic        pcsrc,
    input  logic [25:0] instr_index,
    output npc_sel_e    sel,
    output logic [31:0] target
);

    logic [31:0] raw_s;

    // Pick the redirect source; jump outranks a taken branch.
    always_comb begin
        sel   = SEQ;
        raw_s = pc_seq;
        if (jump) begin
            sel   = JUMP;
            raw_s = {pc_region, instr_index, 2'b00};
        end else if (pcsrc) begin
            sel   = BRANCH;
            raw_s = pcbranch;
        end else begin
            sel   = SEQ;
            raw_s = pc_seq;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    assign target = raw_s;
`else
    assign target = raw_s & 32'hFFFF_FFFC;
`endif

endmodule

// File: rtl/pc_fetch.sv
// PC register and instruction fetch with valid/ack memory handshake, skid buffer and redirect kill.
// Optional PC_ALIGN_CHECK_EN: misaligned redirect targets halt fetch and set sticky misaligned.
import mips_pkg::*;

module pc_fetch #(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pcbranch,
    input  logic        pcsrc,
    input  logic        jump,
    input  logic [25:0] instr_index,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] pcplus4,
    output logic        instr_valid,
    output logic        misaligned
);

    fetch_state_e state_r;
    logic [31:0]  pc_r, addr_r, instr_r, pcplus4_r, skid_instr_r, skid_pcplus4_r;
    logic         req_r, instr_valid_r, kill_r, misaligned_r;

    npc_sel_e     sel_s;
    logic [31:0]  target_s, pc_seq_s;
    logic         consume_s, redirect_s, halt_s, acked_s, outstanding_s;

    assign pc_seq_s = pc_inc(pc_r);

    pc_next_mux u_pc_next_mux (
        .pc_seq      (pc_seq_s),
        .pc_region   (pcplus4_r[31:28]),
        .pcbranch    (pcbranch),
        .jump        (jump),
        .pcsrc       (pcsrc),
        .instr_index (instr_index),
        .sel         (sel_s),
        .target      (target_s)
    );

    // Handshake and redirect qualifiers; redirects only count when decode takes instr.
    always_comb begin
        consume_s     = instr_valid_r && !stall;
        redirect_s    = consume_s && (sel_s != SEQ);
        acked_s       = req_r && imem_ack;
        outstanding_s = req_r && !imem_ack;
`ifdef PC_ALIGN_CHECK_EN
        halt_s        = redirect_s && (target_s[1:0] != 2'b00);
`else
        halt_s        = 1'b0;
`endif
    end

    // Fetch FSM with all datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= FETCH;
            pc_r           <= RESET_PC;
            addr_r         <= RESET_PC;
            req_r          <= 1'b0;
            instr_r        <= 32'h0000_0000;
            pcplus4_r      <= 32'h0000_0000;
            skid_instr_r   <= 32'h0000_0000;
            skid_pcplus4_r <= 32'h0000_0000;
            instr_valid_r  <= 1'b0;
            kill_r         <= 1'b0;
            misaligned_r   <= 1'b0;
        end else begin
            case (state_r)
                FETCH: begin
                    req_r <= 1'b1;
                    if (halt_s) begin
                        state_r       <= HALT;
                        req_r         <= 1'b0;
                        instr_valid_r <= 1'b0;
                        kill_r        <= 1'b0;
                        misaligned_r  <= 1'b1;
                    end else if (redirect_s) begin
                        pc_r          <= target_s;
                        instr_valid_r <= 1'b0;
                        // An un-acked request keeps its address; its ack is dropped later.
                        if (outstanding_s) begin
                            kill_r <= 1'b1;
                        end else begin
                            kill_r <= 1'b0;
                            addr_r <= target_s;
                        end
                    end else if (acked_s && kill_r) begin
                        kill_r <= 1'b0;
                        addr_r <= pc_r;
                        if (consume_s) begin
                            instr_valid_r <= 1'b0;
                        end else begin
                            instr_valid_r <= instr_valid_r;
                        end
                    end else if (acked_s) begin
                        pc_r   <= pc_seq_s;
                        addr_r <= pc_seq_s;
                        if (instr_valid_r && stall) begin
                            skid_instr_r   <= imem_rdata;
                            skid_pcplus4_r <= pc_seq_s;
                            state_r        <= HOLD;
                            req_r          <= 1'b0;
                        end else begin
                            instr_r       <= imem_rdata;
                            pcplus4_r     <= pc_seq_s;
                            instr_valid_r <= 1'b1;
                        end
                    end else begin
                        if (consume_s) begin
                            instr_valid_r <= 1'b0;
                        end else begin
                            instr_valid_r <= instr_valid_r;
                        end
                    end
                end
                HOLD: begin
                    if (!stall) begin
                        state_r <= FETCH;
                        req_r   <= 1'b1;
                        if (halt_s) begin
                            state_r       <= HALT;
                            req_r         <= 1'b0;
                            instr_valid_r <= 1'b0;
                            misaligned_r  <= 1'b1;
                        end else if (redirect_s) begin
                            pc_r          <= target_s;
                            addr_r        <= target_s;
                            instr_valid_r <= 1'b0;
                        end else begin
                            instr_r       <= skid_instr_r;
                            pcplus4_r     <= skid_pcplus4_r;
                            instr_valid_r <= 1'b1;
                        end
                    end else begin
                        req_r <= 1'b0;
                    end
                end
                HALT: begin
                    req_r         <= 1'b0;
                    instr_valid_r <= 1'b0;
                end
                default: begin
                    state_r       <= FETCH;
                    req_r         <= 1'b0;
                    instr_valid_r <= 1'b0;
                    kill_r        <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = addr_r;
    assign instr       = instr_r;
    assign pcplus4     = pcplus4_r;
    assign instr_valid = instr_valid_r;
    assign misaligned  = misaligned_r;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed self-checking bench for pc_fetch; memory returns addr ^ 32'hDEAD_BEEF.
// Expectations for the misaligned redirect follow PC_ALIGN_CHECK_EN.
module tb_pc_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pcbranch;
    logic        pcsrc;
    logic        jump;
    logic [25:0] instr_index;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] pcplus4;
    logic        instr_valid;
    logic        misaligned;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hDEAD_BEEF;

    pc_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .pcbranch    (pcbranch),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .instr_index (instr_index),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .pcplus4     (pcplus4),
        .instr_valid (instr_valid),
        .misaligned  (misaligned)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b1; stall = 1'b0;
        pcsrc = 1'b0; jump = 1'b0; pcbranch = 32'h0; instr_index = 26'h0;
        tick(); tick();
        check_val("rst_req", {31'd0, imem_req}, 32'd0);
        check_val("rst_addr", imem_addr, 32'h0);
        check_val("rst_valid", {31'd0, instr_valid}, 32'd0);
        check_val("rst_instr", instr, 32'h0);
        check_val("rst_pc4", pcplus4, 32'h0);
        check_val("rst_mis", {31'd0, misaligned}, 32'd0);
        reset = 1'b0;

        tick();
        check_val("req_up", {31'd0, imem_req}, 32'd1);
        check_val("addr0", imem_addr, 32'h0);
        check_val("no_early_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_val("addr4", imem_addr, 32'h4);
        check_val("valid_first", {31'd0, instr_valid}, 32'd1);
        check_val("instr0", instr, word_at(32'h0));
        check_val("pc4_first", pcplus4, 32'h4);
        tick();
        check_val("addr8", imem_addr, 32'h8);
        check_val("pc4_8", pcplus4, 32'h8);
        tick();
        check_val("addrC", imem_addr, 32'hC);
        check_val("instr8", instr, word_at(32'h8));

        // Taken branch on the instruction at 8: word at C must be dropped.
        pcsrc = 1'b1; pcbranch = 32'h40;
        tick();
        pcsrc = 1'b0;
        check_val("br_addr", imem_addr, 32'h40);
        check_val("br_killed", {31'd0, instr_valid}, 32'd0);
        tick();
        check_val("br_valid", {31'd0, instr_valid}, 32'd1);
        check_val("br_instr", instr, word_at(32'h40));
        check_val("br_pc4", pcplus4, 32'h44);

        // Move into the 0x1 region, then jump and branch together.
        pcsrc = 1'b1; pcbranch = 32'h1000_0004;
        tick();
        pcsrc = 1'b0;
        check_val("br2_addr", imem_addr, 32'h1000_0004);
        tick();
        check_val("br2_pc4", pcplus4, 32'h1000_0008);
        jump = 1'b1; pcsrc = 1'b1; pcbranch = 32'h40; instr_index = 26'h10;
        tick();
        jump = 1'b0; pcsrc = 1'b0;
        check_val("jmp_addr", imem_addr, 32'h1000_0040);
        tick();
        check_val("jmp_instr", instr, word_at(32'h1000_0040));
        check_val("jmp_pc4", pcplus4, 32'h1000_0044);

        // Stall for three cycles while the next word is acked.
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("hold_req", {31'd0, imem_req}, 32'd0);
            check_val("hold_instr", instr, word_at(32'h1000_0040));
            check_val("hold_pc4", pcplus4, 32'h1000_0044);
        end
        stall = 1'b0;
        tick();
        check_val("skid_instr", instr, word_at(32'h1000_0044));
        check_val("skid_pc4", pcplus4, 32'h1000_0048);
        check_val("skid_valid", {31'd0, instr_valid}, 32'd1);
        check_val("skid_req", {31'd0, imem_req}, 32'd1);
        tick();
        check_val("after_skid", instr, word_at(32'h1000_0048));
        check_val("after_skid_pc4", pcplus4, 32'h1000_004C);

        // Slow memory; redirect while the request to ...4C is outstanding.
        imem_ack = 1'b0; stall = 1'b1;
        tick();
        check_val("slow_addr1", imem_addr, 32'h1000_004C);
        check_val("slow_valid", {31'd0, instr_valid}, 32'd1);
        stall = 1'b0; pcsrc = 1'b1; pcbranch = 32'h80;
        tick();
        pcsrc = 1'b0;
        check_val("kill_addr", imem_addr, 32'h1000_004C);
        check_val("kill_req", {31'd0, imem_req}, 32'd1);
        check_val("kill_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        check_val("kill_addr2", imem_addr, 32'h1000_004C);
        imem_ack = 1'b1;
        tick();
        check_val("killed_drop", {31'd0, instr_valid}, 32'd0);
        check_val("reissue_addr", imem_addr, 32'h80);
        tick();
        check_val("tgt80_instr", instr, word_at(32'h80));
        check_val("tgt80_pc4", pcplus4, 32'h84);

        // Wrap at the top of the address space.
        pcsrc = 1'b1; pcbranch = 32'hFFFF_FFFC;
        tick();
        pcsrc = 1'b0;
        check_val("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        tick();
        check_val("wrap_instr", instr, word_at(32'hFFFF_FFFC));
        check_val("wrap_pc4", pcplus4, 32'h0);
        check_val("wrap_next", imem_addr, 32'h0);

        // Misaligned branch target.
        pcsrc = 1'b1; pcbranch = 32'h42;
        tick();
        pcsrc = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        check_val("mis_flag", {31'd0, misaligned}, 32'd1);
        check_val("mis_req", {31'd0, imem_req}, 32'd0);
        tick();
        check_val("halt_flag", {31'd0, misaligned}, 32'd1);
        check_val("halt_req", {31'd0, imem_req}, 32'd0);
        check_val("halt_valid", {31'd0, instr_valid}, 32'd0);
`else
        check_val("mis_flag", {31'd0, misaligned}, 32'd0);
        check_val("mis_addr", imem_addr, 32'h40);
        tick();
        check_val("mis_instr", instr, word_at(32'h40));
        check_val("mis_valid", {31'd0, instr_valid}, 32'd1);
`endif

        reset = 1'b1;
        tick();
        check_val("rst2_mis", {31'd0, misaligned}, 32'd0);
        check_val("rst2_req", {31'd0, imem_req}, 32'd0);
        check_val("rst2_addr", imem_addr, 32'h0);
        check_val("rst2_valid", {31'd0, instr_valid}, 32'd0);
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pc_fetch.md
# pc_fetch

Program-counter and instruction-fetch stage of the MIPS datapath. It holds the PC, requests instruction words from instruction memory over a valid/ack handshake, and presents each fetched instruction with its PC+4 to decode. It consumes the outputs of branch_adder (pcbranch) and the jump/branch decisions to redirect fetch. It produces the pcplus4 that feeds branch_adder.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset (word aligned)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- pcbranch  input  32  branch target from branch_adder
- pcsrc  input  1  branch taken (beq true) for the instruction on instr
- jump  input  1  jump for the instruction on instr
- instr_index  input  26  jump index field of instr
- stall  input  1  decode cannot accept instr this cycle
- imem_req  output  1  fetch request valid
- imem_addr  output  32  fetch word address
- imem_ack  input  1  memory returns imem_rdata this cycle
- imem_rdata  input  32  fetched instruction word
- instr  output  32  instruction presented to decode
- pcplus4  output  32  address of instr + 4
- instr_valid  output  1  instr/pcplus4 valid
- misaligned  output  1  redirect target not word aligned (sticky)

## Operation
- Registers: pc, instr, pcplus4, instr_valid, kill, state.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0. Instruction buffered, waiting on stall.
  - HALT: misaligned, no requests.
- Consume event: instr_valid && !stall. Redirect is sampled only on a consume event.
- Redirect priority: jump > pcsrc > sequential.
  - Jump target: {pcplus4[31:28], instr_index, 2'b00}.
  - Branch target: pcbranch.
- FETCH, ack, no kill, no redirect: instr<=imem_rdata, pcplus4<=pc+4, instr_valid<=1, pc<=pc+4.
  - If instr_valid && stall also hold: do not overwrite the buffer. Go to HOLD and keep the returned word in a one-entry skid register.
- FETCH with a redirect on a consume event:
  - pc<=target.
  - A returning or outstanding wrong-path word is discarded: kill<=1 if a request is outstanding and not acked this cycle. The next ack clears kill and is dropped.
  - instr_valid<=0 unless a kept word is available.
- HOLD -> FETCH when stall=0 (consume). Skid contents move to instr. Redirect applies as above.
- imem_addr is stable while imem_req=1 and no ack. A pc change mid-request is hidden by kill; the request is reissued at the new pc after the killed ack.
- Arithmetic: all adds are 32-bit modulo. pc=32'hFFFF_FFFC sequential wraps to 0. The carry is discarded.
- reset (any state, mid-request): all registers take reset values next edge. A late ack after reset is ignored, because kill is cleared and imem_req=0 in the reset cycle.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=0, pcplus4=0, instr_valid=0, misaligned=0, kill=0, state=FETCH.
- imem_req=1 from the first cycle after reset deasserts.
- Latency: ack at edge N gives instr_valid=1 from cycle N+1.
- Throughput: with ack tied high and stall=0, one instruction per cycle.
- Redirect penalty: one killed word. The first target instruction is valid 2 cycles after the redirect edge when ack is immediate.
- Simultaneous ack + redirect: the acked word is dropped and the next request goes to the target.
- Simultaneous jump + pcsrc: jump wins.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - A redirect target with [1:0]!=0 sets misaligned (sticky until reset) and moves to HALT.
  - In HALT: imem_req=0, instr_valid=0.
- PC_ALIGN_CHECK_EN undefined:
  - Target bits [1:0] are forced to 00.
  - misaligned is tied 0 and HALT is unreachable.

## Structure
- mips_pkg:
  - fetch state enum (FETCH/HOLD/HALT).
  - next-PC select encoding (SEQ/BRANCH/JUMP).
  - PC_WIDTH=32 and default RESET_PC.
- Sub-module pc_next_mux: combinational priority select of target, with jump-target formation.

## Test plan
- Reset, ack tied 1, stall 0 -> imem_addr 0,4,8,C on consecutive cycles. instr_valid rises the cycle after the first ack. pcplus4=4 with the first instr.
- instr at pc 8 with pcsrc=1, pcbranch=32'h40, ack tied 1 -> word at C dropped. Next valid instr comes from 32'h40 with pcplus4=32'h44.
- jump=1, pcsrc=1, instr_index=26'h10, pcplus4=32'h1000_0008 -> fetch at 32'h1000_0040.
- stall held 3 cycles while an ack returns -> instr unchanged and imem_req=0 during HOLD. The buffered word is presented the cycle after stall drops, with no word lost or duplicated.
- Ack delayed 4 cycles, redirect to 32'h80 on cycle 2 -> the first ack is dropped and the next request is to 32'h80 with a stable address.
- PC_ALIGN_CHECK_EN, pcbranch=32'h42 taken -> misaligned=1, imem_req=0 until reset. Without the macro, fetch goes to 32'h40.
